// File: rtl/toggle_decoder_pkg.sv
// Shared definitions for the toggle decoder.
// The FSM has two states: PRIME takes the first sampled level as the
// reference, and RUN decodes every later sample against the one before it.
package toggle_decoder_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/tdiff_bit.sv
// One bit of the toggle decoder: a previous-level flop plus edge detection.
// Ports:
//   CLK   in  rising-edge clock
//   RESET in  asynchronous active-high reset
//   D     in  level bit being watched
//   EN    in  sample strobe; PREV loads D only when EN=1
//   ARM   in  1 once the reference level is primed; enables the pulses
//   T     out registered toggle pulse (D differed from PREV)
//   R     out registered rising-edge pulse (0->1)
//   F     out registered falling-edge pulse (1->0)
//   DIFF  out combinational D^PREV. The parent registers it into its
//             capture buffer on the same edge that registers T.
module tdiff_bit (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  input  logic EN,
  input  logic ARM,
  output logic T,
  output logic R,
  output logic F,
  output logic DIFF
);

  logic prev_q;
  logic t_q;
  logic r_q;
  logic f_q;

  assign DIFF = D ^ prev_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q <= 1'b0;
      t_q    <= 1'b0;
      r_q    <= 1'b0;
      f_q    <= 1'b0;
    end else begin
      // Pulses default low, so they last exactly one cycle.
      t_q <= 1'b0;
      r_q <= 1'b0;
      f_q <= 1'b0;
      if (EN) begin
        prev_q <= D;
        if (ARM) begin
          t_q <= DIFF;
          r_q <= DIFF & D;
          f_q <= DIFF & ~D;
        end
      end
    end
  end

  assign T = t_q;
  assign R = r_q;
  assign F = f_q;

endmodule

// File: rtl/toggle_decoder.sv
// Recovers the per-bit toggle vector behind each change of a level bus.
// It emits T/RISE/FALL pulses, counts change events with saturation, and
// holds the most recent event in a one-entry VALID/ACK buffer. OVF is a
// sticky flag for events dropped while the buffer was full.
// Ports:
//   CLK    in  rising-edge clock
//   RESET  in  asynchronous active-high reset
//   IN     in  [WIDTH] level bus, synchronous to CLK
//   EN     in  sample strobe; IN is examined only when EN=1
//   CLR    in  synchronous clear of COUNT and OVF (wins over set/increment)
//   ACK    in  consumer accepts DATA while VALID=1
//   T_OUT  out [WIDTH] toggle vector pulse
//   RISE   out [WIDTH] 0->1 pulse
//   FALL   out [WIDTH] 1->0 pulse
//   DATA   out [WIDTH] captured toggle vector, held while VALID
//   VALID  out buffer holds an unacknowledged event
//   OVF    out sticky: an event was dropped because the buffer was full
//   COUNT  out [CNT_W] saturating change-event count
//   STATE  out FSM state (debug observation: 0=PRIME, 1=RUN)
// Handshake: a DATA transfer happens on an edge where VALID=1 and ACK=1.
// A new event on that same edge refills the buffer, so VALID stays 1.
// ACK is ignored while VALID=0.
module toggle_decoder
  import toggle_decoder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic             EN,
  input  logic             CLR,
  input  logic             ACK,
  output logic [WIDTH-1:0] T_OUT,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  output logic             OVF,
  output logic [CNT_W-1:0] COUNT,
  output logic             STATE
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] diff_w;
  logic             arm_w;
  logic             event_w;

  assign arm_w   = (state_q == ST_RUN);
  assign event_w = EN && arm_w && (|diff_w);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tdiff_bit u_bit (
      .CLK  (CLK),
      .RESET(RESET),
      .D    (IN[i]),
      .EN   (EN),
      .ARM  (arm_w),
      .T    (T_OUT[i]),
      .R    (RISE[i]),
      .F    (FALL[i]),
      .DIFF (diff_w[i])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_PRIME;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      // The first EN edge only primes PREV inside the bit slices.
      if (state_q == ST_PRIME && EN) begin
        state_q <= ST_RUN;
      end

      if (event_w) begin
        if (!valid_q || ACK) begin
          data_q  <= diff_w;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && ACK) begin
        valid_q <= 1'b0;
      end

      // Dropped events still count.
      if (event_w && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end

      // CLR is placed last so that it overrides an overflow or an increment in the same cycle.
      if (CLR) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign OVF   = ovf_q;
  assign COUNT = count_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_toggle_decoder.sv
module tb_toggle_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] in_v;
  logic       en;
  logic       clr;
  logic       ack;
  logic [3:0] t_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] data;
  logic       valid;
  logic       ovf;
  logic [7:0] count;
  logic       state;

  int checks;
  int failures;

  toggle_decoder #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK  (clk),
    .RESET(rst),
    .IN   (in_v),
    .EN   (en),
    .CLR  (clr),
    .ACK  (ack),
    .T_OUT(t_out),
    .RISE (rise),
    .FALL (fall),
    .DATA (data),
    .VALID(valid),
    .OVF  (ovf),
    .COUNT(count),
    .STATE(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    in_v = 4'h0;
    en   = 1'b0;
    clr  = 1'b0;
    ack  = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (t_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || data !== 4'h0) begin
      failures++;
      $display("FAIL reset_vec t=%h r=%h f=%h d=%h expected all 0", t_out, rise, fall, data);
    end
    checks++;
    if (valid !== 1'b0 || ovf !== 1'b0 || count !== 8'd0 || state !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl valid=%b ovf=%b count=%0d state=%b expected 0/0/0/0",
               valid, ovf, count, state);
    end
  endtask

  task automatic test_prime_only();
    apply_reset();
    en   = 1'b1;
    in_v = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (t_out !== 4'h0 || valid !== 1'b0 || count !== 8'd0) begin
        failures++;
        $display("FAIL prime_cyc%0d t=%h valid=%b count=%0d expected 0/0/0", i, t_out, valid, count);
      end
    end
    checks++;
    if (state !== 1'b1) begin
      failures++;
      $display("FAIL prime_state state=%b expected 1", state);
    end
  endtask

  // Covers the first event, overflow, CLR, and ACK arriving on the same edge as an event.
  task automatic test_event_ovf_ack();
    apply_reset();
    en   = 1'b1;
    in_v = 4'b0000;
    step();
    in_v = 4'b0101;
    step();
    checks++;
    if (t_out !== 4'b0101 || rise !== 4'b0101 || fall !== 4'b0000) begin
      failures++;
      $display("FAIL first_pulse t=%b r=%b f=%b expected 0101/0101/0000", t_out, rise, fall);
    end
    checks++;
    if (data !== 4'b0101 || valid !== 1'b1 || count !== 8'd1) begin
      failures++;
      $display("FAIL first_buf data=%b valid=%b count=%0d expected 0101/1/1", data, valid, count);
    end
    step();
    checks++;
    if (t_out !== 4'h0 || rise !== 4'h0 || count !== 8'd1) begin
      failures++;
      $display("FAIL pulse_drop t=%b r=%b count=%0d expected 0000/0000/1", t_out, rise, count);
    end

    in_v = 4'b0111;
    step();
    checks++;
    if (data !== 4'b0101 || ovf !== 1'b1 || count !== 8'd2 || t_out !== 4'b0010) begin
      failures++;
      $display("FAIL overflow data=%b ovf=%b count=%0d t=%b expected 0101/1/2/0010",
               data, ovf, count, t_out);
    end

    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (ovf !== 1'b0 || count !== 8'd0 || valid !== 1'b1 || data !== 4'b0101) begin
      failures++;
      $display("FAIL clear ovf=%b count=%0d valid=%b data=%b expected 0/0/1/0101",
               ovf, count, valid, data);
    end

    // The ACK edge takes the old entry and captures the new event.
    in_v = 4'b0011;
    ack  = 1'b1;
    step();
    checks++;
    if (data !== 4'b0100 || valid !== 1'b1 || ovf !== 1'b0 || fall !== 4'b0100 || count !== 8'd1) begin
      failures++;
      $display("FAIL ack_event data=%b valid=%b ovf=%b fall=%b count=%0d expected 0100/1/0/0100/1",
               data, valid, ovf, fall, count);
    end

    // An ACK with no event drains the buffer; DATA keeps its value.
    step();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || data !== 4'b0100) begin
      failures++;
      $display("FAIL ack_drain valid=%b data=%b expected 0/0100", valid, data);
    end

    // With EN low the bus is not examined.
    en   = 1'b0;
    in_v = 4'b1100;
    step();
    checks++;
    if (t_out !== 4'h0 || valid !== 1'b0 || count !== 8'd1) begin
      failures++;
      $display("FAIL en_gate t=%b valid=%b count=%0d expected 0000/0/1", t_out, valid, count);
    end
    // PREV stayed at 0011, so re-enabling decodes 1100^0011.
    en = 1'b1;
    step();
    checks++;
    if (t_out !== 4'b1111 || rise !== 4'b1100 || fall !== 4'b0011) begin
      failures++;
      $display("FAIL en_resume t=%b r=%b f=%b expected 1111/1100/0011", t_out, rise, fall);
    end
  endtask

  task automatic test_random();
    logic [3:0] acc;
    logic [3:0] prev_m;
    logic [3:0] diff_m;
    logic [3:0] data_m;
    logic       valid_m;
    logic       ovf_m;
    int         cnt_m;
    int         bad;
    apply_reset();
    en   = 1'b1;
    in_v = 4'($urandom_range(0, 15));
    step();
    acc     = in_v;
    prev_m  = in_v;
    data_m  = 4'h0;
    valid_m = 1'b0;
    ovf_m   = 1'b0;
    cnt_m   = 0;
    bad     = 0;
    for (int i = 0; i < 200; i++) begin
      in_v = 4'($urandom_range(0, 15));
      en   = 1'($urandom_range(0, 1));
      ack  = 1'($urandom_range(0, 1));
      // Reference model of the buffer and counter
      if (en) begin
        diff_m = in_v ^ prev_m;
        prev_m = in_v;
        if (diff_m != 4'h0) begin
          if (cnt_m < 255) cnt_m++;
          if (!valid_m || ack) begin
            data_m  = diff_m;
            valid_m = 1'b1;
          end else begin
            ovf_m = 1'b1;
          end
        end else if (valid_m && ack) begin
          valid_m = 1'b0;
        end
      end else if (valid_m && ack) begin
        valid_m = 1'b0;
      end
      step();
      if (en) acc = acc ^ t_out;
      if ((en && acc !== in_v) || (!en && t_out !== 4'h0) || ((rise | fall) !== t_out) ||
          ((rise & fall) !== 4'h0) || data !== data_m || valid !== valid_m ||
          ovf !== ovf_m || count !== 8'(cnt_m)) begin
        if (bad < 5)
          $display("FAIL rand_step%0d in=%h acc=%h t=%h r=%h f=%h d=%h/%h v=%b/%b o=%b/%b c=%0d/%0d",
                   i, in_v, acc, t_out, rise, fall, data, data_m, valid, valid_m, ovf, ovf_m,
                   count, cnt_m);
        bad++;
      end
    end
    ack = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rand_summary bad_steps=%0d expected 0", bad);
    end
  endtask

  task automatic test_saturate_and_async_reset();
    apply_reset();
    en   = 1'b1;
    ack  = 1'b1;
    in_v = 4'b0000;
    step();
    for (int i = 1; i <= 300; i++) begin
      in_v = in_v ^ 4'b0001;
      step();
      if (i == 254) begin
        checks++;
        if (count !== 8'd254) begin
          failures++;
          $display("FAIL count_254 count=%0d expected 254", count);
        end
      end
      if (i == 255) begin
        checks++;
        if (count !== 8'd255) begin
          failures++;
          $display("FAIL count_255 count=%0d expected 255", count);
        end
      end
    end
    checks++;
    if (count !== 8'd255) begin
      failures++;
      $display("FAIL count_sat count=%0d expected 255", count);
    end
    // Change IN once more so that T_OUT is non-zero when the reset arrives.
    in_v = in_v ^ 4'b1001;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (t_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || data !== 4'h0 ||
        valid !== 1'b0 || ovf !== 1'b0 || count !== 8'd0 || state !== 1'b0) begin
      failures++;
      $display("FAIL async_reset t=%h r=%h f=%h d=%h v=%b o=%b c=%0d s=%b expected all 0",
               t_out, rise, fall, data, valid, ovf, count, state);
    end
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    // After reset the first sample only primes again.
    in_v = 4'b0110;
    step();
    checks++;
    if (t_out !== 4'h0 || state !== 1'b1 || count !== 8'd0) begin
      failures++;
      $display("FAIL reprime t=%h state=%b count=%0d expected 0/1/0", t_out, state, count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    in_v = 4'h0;
    en   = 1'b0;
    clr  = 1'b0;
    ack  = 1'b0;
    test_reset();
    test_prime_only();
    test_event_ovf_ack();
    test_random();
    test_saturate_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
